axi_rr_arbiter_n: RTL

Parametrised N-master AXI4-Lite arbiter that places NR_MST core-side masters (IFU, LSU, future DMA/debug) onto one AXI4-Lite slave port toward the crossbar/memory. Read (AR/R) and write (AW/W/B) paths are arbitrated independently and may be active at the same time. Each path uses a fair round-robin grant with one outstanding transaction. Responses and readies are routed only to the granted master; non-granted masters see valid and ready at 0.

---
 rtl/axi_rr_arbiter_n.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_rr_arbiter_n.sv
// ============================================================================
// axi_rr_arbiter_n : N-master AXI4-Lite round-robin arbiter, independent R/W
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_rr_arbiter_n #(
  parameter  int NR_MST = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // master side
  input  logic [NR_MST-1:0]          s_ar_valid_i,
  input  logic [NR_MST*ADDR_W-1:0]   s_ar_addr_i,
  output logic [NR_MST-1:0]          s_ar_ready_o,
  output logic [NR_MST-1:0]          s_r_valid_o,
  output logic [NR_MST*DATA_W-1:0]   s_r_data_o,
  output logic [NR_MST*2-1:0]        s_r_resp_o,
  input  logic [NR_MST-1:0]          s_r_ready_i,
  input  logic [NR_MST-1:0]          s_aw_valid_i,
  input  logic [NR_MST*ADDR_W-1:0]   s_aw_addr_i,
  output logic [NR_MST-1:0]          s_aw_ready_o,
  input  logic [NR_MST-1:0]          s_w_valid_i,
  input  logic [NR_MST*DATA_W-1:0]   s_w_data_i,
  input  logic [NR_MST*STRB_W-1:0]   s_w_strb_i,
  output logic [NR_MST-1:0]          s_w_ready_o,
  output logic [NR_MST-1:0]          s_b_valid_o,
  output logic [NR_MST*2-1:0]        s_b_resp_o,
  input  logic [NR_MST-1:0]          s_b_ready_i,
  // slave side
  output logic                       mst_ar_valid_o,
  output logic [ADDR_W-1:0]          mst_ar_addr_o,
  input  logic                       mst_ar_ready_i,
  input  logic                       mst_r_valid_i,
  input  logic [DATA_W-1:0]          mst_r_data_i,
  input  logic [1:0]                 mst_r_resp_i,
  output logic                       mst_r_ready_o,
  output logic                       mst_aw_valid_o,
  output logic [ADDR_W-1:0]          mst_aw_addr_o,
  input  logic                       mst_aw_ready_i,
  output logic                       mst_w_valid_o,
  output logic [DATA_W-1:0]          mst_w_data_o,
  output logic [STRB_W-1:0]          mst_w_strb_o,
  input  logic                       mst_w_ready_i,
  input  logic                       mst_b_valid_i,
  input  logic [1:0]                 mst_b_resp_i,
  output logic                       mst_b_ready_o
);

  localparam int GW = (NR_MST > 1) ? $clog2(NR_MST) : 1;
  localparam int IW = GW + 1;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_REQ  = 3'b010,
    R_RSP  = 3'b100
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_REQ  = 3'b010,
    W_RSP  = 3'b100
  } wr_state_e;

  rd_state_e         rd_state_q, rd_state_d;
  wr_state_e         wr_state_q, wr_state_d;
  logic [GW-1:0]     rd_gnt_q, rd_gnt_d, rd_ptr_q, rd_ptr_d;
  logic [GW-1:0]     wr_gnt_q, wr_gnt_d, wr_ptr_q, wr_ptr_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [NR_MST-1:0] wr_req;

  // First requester at or after ptr, wrapping modulo NR_MST.
  function automatic logic [GW-1:0] rr_pick(input logic [NR_MST-1:0] req,
                                            input logic [GW-1:0]     ptr);
    logic [GW-1:0] pick;
    logic          found;
    logic [IW-1:0] idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NR_MST; i++) begin
      idx = {1'b0, ptr} + IW'(i);
      if (idx >= IW'(NR_MST)) idx = idx - IW'(NR_MST);
      if (!found && req[idx[GW-1:0]]) begin
        pick  = idx[GW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] g);
    logic [GW-1:0] n;
    if (int'(g) == NR_MST - 1) n = '0;
    else                       n = g + 1'b1;
    return n;
  endfunction

  assign s_r_data_o = {NR_MST{mst_r_data_i}};
  assign s_r_resp_o = {NR_MST{mst_r_resp_i}};
  assign s_b_resp_o = {NR_MST{mst_b_resp_i}};
  assign wr_req     = s_aw_valid_i | s_w_valid_i;

  always_comb begin
    rd_state_d     = rd_state_q;
    rd_gnt_d       = rd_gnt_q;
    rd_ptr_d       = rd_ptr_q;
    s_ar_ready_o   = '0;
    s_r_valid_o    = '0;
    mst_ar_valid_o = 1'b0;
    mst_r_ready_o  = 1'b0;
    mst_ar_addr_o  = s_ar_addr_i[int'(rd_gnt_q)*ADDR_W +: ADDR_W];
    case (rd_state_q)
      R_IDLE: begin
        if (|s_ar_valid_i) begin
          rd_gnt_d   = rr_pick(s_ar_valid_i, rd_ptr_q);
          rd_state_d = R_REQ;
        end
      end
      R_REQ: begin
        mst_ar_valid_o         = s_ar_valid_i[rd_gnt_q];
        s_ar_ready_o[rd_gnt_q] = mst_ar_ready_i;
        if (mst_ar_valid_o && mst_ar_ready_i) rd_state_d = R_RSP;
      end
      R_RSP: begin
        s_r_valid_o[rd_gnt_q] = mst_r_valid_i;
        mst_r_ready_o         = s_r_ready_i[rd_gnt_q];
        if (mst_r_valid_i && mst_r_ready_o) begin
          rd_ptr_d   = next_idx(rd_gnt_q);
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d     = wr_state_q;
    wr_gnt_d       = wr_gnt_q;
    wr_ptr_d       = wr_ptr_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    s_aw_ready_o   = '0;
    s_w_ready_o    = '0;
    s_b_valid_o    = '0;
    mst_aw_valid_o = 1'b0;
    mst_w_valid_o  = 1'b0;
    mst_b_ready_o  = 1'b0;
    mst_aw_addr_o  = s_aw_addr_i[int'(wr_gnt_q)*ADDR_W +: ADDR_W];
    mst_w_data_o   = s_w_data_i[int'(wr_gnt_q)*DATA_W +: DATA_W];
    mst_w_strb_o   = s_w_strb_i[int'(wr_gnt_q)*STRB_W +: STRB_W];
    case (wr_state_q)
      W_IDLE: begin
        if (|wr_req) begin
          wr_gnt_d   = rr_pick(wr_req, wr_ptr_q);
          wr_state_d = W_REQ;
        end
      end
      W_REQ: begin
        // A completed channel is masked so it is never offered twice.
        mst_aw_valid_o         = s_aw_valid_i[wr_gnt_q] & ~aw_done_q;
        s_aw_ready_o[wr_gnt_q] = mst_aw_ready_i & ~aw_done_q;
        mst_w_valid_o          = s_w_valid_i[wr_gnt_q] & ~w_done_q;
        s_w_ready_o[wr_gnt_q]  = mst_w_ready_i & ~w_done_q;
        aw_done_d = aw_done_q | (mst_aw_valid_o & mst_aw_ready_i);
        w_done_d  = w_done_q  | (mst_w_valid_o  & mst_w_ready_i);
        if (aw_done_d && w_done_d) wr_state_d = W_RSP;
      end
      W_RSP: begin
        s_b_valid_o[wr_gnt_q] = mst_b_valid_i;
        mst_b_ready_o         = s_b_ready_i[wr_gnt_q];
        if (mst_b_valid_i && mst_b_ready_o) begin
          wr_ptr_d   = next_idx(wr_gnt_q);
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      rd_gnt_q   <= '0;
      rd_ptr_q   <= '0;
      wr_state_q <= W_IDLE;
      wr_gnt_q   <= '0;
      wr_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_state_q <= wr_state_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_ptr_q   <= wr_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

`default_nettype wire
